// File: rtl/led_mux.sv
// led_mux: picks one RDID byte (live or snapshot) for the 8 board LEDs,
// with a lamp test on select 3 and an optional blink.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   SW[1:0]         byte select: 0 capacity, 1 type, 2 manufacturer, 3 all-on
//   SW[2]           1 = show snapshot registers, 0 = show live inputs
//   SW[3]           1 = blink the display
//   SW[7:4]         unused
//   memory_capacity live RDID byte 3
//   memory_type     live RDID byte 2
//   manufacture_id  live RDID byte 1
//   id_valid        one-cycle strobe; loads the snapshot
//   LED             displayed byte (combinational)
//   snap_valid      a snapshot has been taken since reset
module led_mux #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] SW,
  input  logic [7:0] memory_capacity,
  input  logic [7:0] memory_type,
  input  logic [7:0] manufacture_id,
  input  logic       id_valid,
  output logic [7:0] LED,
  output logic       snap_valid
);

  // A divider of 1 still needs a one-bit counter.
  localparam int CW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(BLINK_DIV - 1);

  logic [7:0]    snap_cap;
  logic [7:0]    snap_type;
  logic [7:0]    snap_mfg;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;
  logic [7:0]    src_cap;
  logic [7:0]    src_type;
  logic [7:0]    src_mfg;
  logic [7:0]    sel_byte;
  logic          unused_sw;

  assign unused_sw = ^SW[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_cap   <= 8'h00;
      snap_type  <= 8'h00;
      snap_mfg   <= 8'h00;
      snap_valid <= 1'b0;
    end else if (id_valid) begin
      snap_cap   <= memory_capacity;
      snap_type  <= memory_type;
      snap_mfg   <= manufacture_id;
      snap_valid <= 1'b1;
    end
  end

  // Free-running; phase flips on the wrap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    src_cap  = memory_capacity;
    src_type = memory_type;
    src_mfg  = manufacture_id;
    if (SW[2]) begin
      src_cap  = snap_cap;
      src_type = snap_type;
      src_mfg  = snap_mfg;
    end
  end

  always_comb begin
    sel_byte = 8'hFF;
    unique case (SW[1:0])
      2'b00:   sel_byte = src_cap;
      2'b01:   sel_byte = src_type;
      2'b10:   sel_byte = src_mfg;
      default: sel_byte = 8'hFF;
    endcase
  end

  always_comb begin
    LED = sel_byte;
    if (SW[3]) LED = sel_byte & {8{blink_phase}};
  end

endmodule

// File: tb/tb_led_mux.sv
// tb_led_mux: vector table plus scoreboard queue for led_mux,
// with short sequences for snapshot, async reset and blink.
module tb_led_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] SW;
  logic [7:0] memory_capacity;
  logic [7:0] memory_type;
  logic [7:0] manufacture_id;
  logic       id_valid;
  logic [7:0] LED;
  logic       snap_valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];

  typedef struct {
    string      name;
    logic [7:0] sw;
    logic [7:0] cap;
    logic [7:0] typ;
    logic [7:0] mfg;
    logic [7:0] led;
  } vec_t;

  vec_t live_v[8];
  vec_t held_v[5];

  led_mux #(.BLINK_DIV(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .SW              (SW),
    .memory_capacity (memory_capacity),
    .memory_type     (memory_type),
    .manufacture_id  (manufacture_id),
    .id_valid        (id_valid),
    .LED             (LED),
    .snap_valid      (snap_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h",
               nm, act, exp);
    end
  endtask

  task automatic chk_led(input string nm);
    logic [7:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %02h want none (empty)",
               nm, LED);
    end else begin
      e = sb.pop_front();
      chk(nm, LED, e);
    end
  endtask

  task automatic apply(input vec_t v);
    SW              = v.sw;
    memory_capacity = v.cap;
    memory_type     = v.typ;
    manufacture_id  = v.mfg;
    sb.push_back(v.led);
    #1;
    chk_led(v.name);
    #9;
  endtask

  initial begin
    live_v[0] = '{"live_cap",  8'h00, 8'h00, 8'h01, 8'h02, 8'h00};
    live_v[1] = '{"live_type", 8'h01, 8'h00, 8'h01, 8'h02, 8'h01};
    live_v[2] = '{"live_mfg",  8'h02, 8'h00, 8'h01, 8'h02, 8'h02};
    live_v[3] = '{"live_lamp", 8'h03, 8'h00, 8'h01, 8'h02, 8'hFF};
    live_v[4] = '{"live_mfg20",8'h02, 8'h11, 8'h22, 8'h20, 8'h20};
    live_v[5] = '{"live_mfgEF",8'h02, 8'h11, 8'h22, 8'hEF, 8'hEF};
    live_v[6] = '{"hi_sw_ign", 8'hF1, 8'h3C, 8'hA5, 8'h5A, 8'hA5};
    live_v[7] = '{"hi_sw_cap", 8'h70, 8'h3C, 8'hA5, 8'h5A, 8'h3C};

    held_v[0] = '{"held_cap",  8'h04, 8'h55, 8'h55, 8'h55, 8'h18};
    held_v[1] = '{"held_type", 8'h05, 8'h55, 8'h55, 8'h55, 8'h20};
    held_v[2] = '{"held_mfg",  8'h06, 8'h55, 8'h55, 8'h55, 8'h20};
    held_v[3] = '{"held_lamp", 8'h07, 8'h55, 8'h55, 8'h55, 8'hFF};
    held_v[4] = '{"live_55",   8'h00, 8'h55, 8'h55, 8'h55, 8'h55};

    reset           = 1'b1;
    id_valid        = 1'b0;
    SW              = 8'h04;
    memory_capacity = 8'h77;
    memory_type     = 8'h66;
    manufacture_id  = 8'h99;
    #3;
    chk("rst_snap_valid", {7'd0, snap_valid}, 8'h00);
    chk("rst_held_led", LED, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    SW = 8'h05;
    #1;
    chk("precap_held", LED, 8'h00);

    for (int i = 0; i < 8; i++) apply(live_v[i]);

    // snapshot capture
    @(negedge clk);
    memory_capacity = 8'h18;
    memory_type     = 8'h20;
    manufacture_id  = 8'h20;
    id_valid        = 1'b1;
    @(posedge clk);
    #1;
    id_valid        = 1'b0;
    memory_capacity = 8'h55;
    memory_type     = 8'h55;
    manufacture_id  = 8'h55;
    chk("cap_snap_valid", {7'd0, snap_valid}, 8'h01);
    for (int i = 0; i < 5; i++) apply(held_v[i]);

    // async reset between edges in held mode
    @(negedge clk);
    #2;
    SW    = 8'h04;
    reset = 1'b1;
    #1;
    chk("arst_held_led", LED, 8'h00);
    chk("arst_snap_valid", {7'd0, snap_valid}, 8'h00);
    SW = 8'h07;
    #1;
    chk("arst_lamp", LED, 8'hFF);
    SW = 8'h02;
    #1;
    chk("arst_live", LED, 8'h55);

    // reset wins over a simultaneous capture
    memory_capacity = 8'hAA;
    memory_type     = 8'hAB;
    manufacture_id  = 8'hAC;
    id_valid        = 1'b1;
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    SW    = 8'h04;
    #1;
    chk("rvc_held_cap", LED, 8'h00);
    chk("rvc_snap_valid", {7'd0, snap_valid}, 8'h00);

    // blink: 4 cycles on, 4 off
    @(negedge clk);
    SW    = 8'h0B;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      sb.push_back(((k / 4) % 2 == 0) ? 8'hFF : 8'h00);
      chk_led($sformatf("blink_%0d", k));
    end

    // blink off: steady lamp test
    SW = 8'h03;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      sb.push_back(8'hFF);
      chk_led($sformatf("steady_%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
